// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman movement logic.
//   - Direction encoding used by pac_dir and the ghost direction registers.
//   - Character type numbers as seen on the character register port.
//   - Movement sequencer FSM state encoding.
//   - One-step helper for the ghost-direction LFSR.
package pacman_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;   // y-1
    localparam logic [1:0] DIR_RIGHT = 2'b01;   // x+1
    localparam logic [1:0] DIR_DOWN  = 2'b10;   // y+1
    localparam logic [1:0] DIR_LEFT  = 2'b11;   // x-1

    localparam logic [2:0] TYPE_PACMAN = 3'd0;
    localparam logic [2:0] TYPE_GHOST1 = 3'd1;
    localparam logic [2:0] TYPE_GHOST2 = 3'd2;
    localparam logic [2:0] TYPE_GHOST3 = 3'd3;
    localparam logic [2:0] TYPE_GHOST4 = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        LATCH  = 3'd2,
        QUERY  = 3'd3,
        DECIDE = 3'd4,
        WR     = 3'd5,
        FIN    = 3'd6
    } mover_state_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    endfunction

endpackage

// File: rtl/character_mover_if.sv
// Character register port plus wall-map query port of the movement sequencer.
//   master : the mover (drives register strobes/write data and map address)
//   slave  : register file / wall map (returns read data and wall flag)
//   reg_type/reg_en/reg_readwrite/reg_x_wr/reg_y_wr : register access
//   reg_x_rd/reg_y_rd : read data, valid the cycle after a read strobe
//   map_x/map_y : wall query address; map_wall valid one cycle later
interface character_mover_if;
    logic [2:0] reg_type;
    logic       reg_en;
    logic       reg_readwrite;
    logic [4:0] reg_x_wr;
    logic [4:0] reg_y_wr;
    logic [4:0] reg_x_rd;
    logic [4:0] reg_y_rd;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic       map_wall;

    modport master (
        output reg_type, reg_en, reg_readwrite, reg_x_wr, reg_y_wr, map_x, map_y,
        input  reg_x_rd, reg_y_rd, map_wall
    );

    modport slave (
        input  reg_type, reg_en, reg_readwrite, reg_x_wr, reg_y_wr, map_x, map_y,
        output reg_x_rd, reg_y_rd, map_wall
    );
endinterface

// File: rtl/next_cell.sv
// Combinational one-cell stepper with tunnel wrap-around.
//   x, y   : current cell
//   dir    : direction (DIR_UP/RIGHT/DOWN/LEFT)
//   cand_x, cand_y : neighbouring cell, wrapped at the grid edges
// The edge test is made on the unmodified coordinate, so the result
// always stays inside 0..GRID_W-1 / 0..GRID_H-1.
module next_cell
    import pacman_pkg::*;
#(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] cand_x,
    output logic [4:0] cand_y
);
    localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

    always_comb begin
        cand_x = x;
        cand_y = y;
        case (dir)
            DIR_UP:    cand_y = (y == 5'd0)  ? Y_MAX : y - 5'd1;
            DIR_RIGHT: cand_x = (x == X_MAX) ? 5'd0  : x + 5'd1;
            DIR_DOWN:  cand_y = (y == Y_MAX) ? 5'd0  : y + 5'd1;
            default:   cand_x = (x == 5'd0)  ? X_MAX : x - 5'd1;
        endcase
    end
endmodule

// File: rtl/character_mover.sv
// Per-frame movement sequencer for Pacman and the four ghosts.
// On an accepted tick it walks types 0..4: read position, step it in the
// character's direction, ask the wall map, write back the result, and at
// the end publish whether any ghost ended on Pacman's cell.
//   clock_50, reset_n : clock, synchronous active-low reset
//   tick              : start a pass (accepted only in IDLE)
//   pac_dir/_valid    : Pacman direction, latched with an accepted tick
//   bus (master)      : character register port and wall-map port
//   busy, done        : pass in progress / one-cycle completion pulse
//   collision         : result of the last completed pass
module character_mover
    import pacman_pkg::*;
#(
    parameter int         GRID_W    = 20,
    parameter int         GRID_H    = 15,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clock_50,
    input  logic               reset_n,
    input  logic               tick,
    input  logic [1:0]         pac_dir,
    input  logic               pac_dir_valid,
    character_mover_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               collision
);
    mover_state_t state_reg;
    logic [2:0]   idx_reg;
    logic [1:0]   pac_dir_reg;
    logic [1:0]   gdir_reg [0:3];   // ghost 1..4 stored at 0..3
    logic [7:0]   lfsr_reg;
    logic [4:0]   cur_x_reg, cur_y_reg;
    logic [4:0]   cand_x_reg, cand_y_reg;
    logic [4:0]   pac_x_reg, pac_y_reg;
    logic         coll_acc_reg;
    logic         collision_reg;

    logic [2:0]   reg_type_reg;
    logic         reg_en_reg;
    logic         reg_rw_reg;
    logic [4:0]   reg_x_wr_reg, reg_y_wr_reg;
    logic [4:0]   map_x_reg, map_y_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [1:0]   gidx;
    logic [1:0]   step_dir;
    logic [4:0]   step_x, step_y;
    logic [4:0]   nxt_x, nxt_y;

    assign gidx     = 2'(idx_reg - 3'd1);
    assign step_dir = (idx_reg == TYPE_PACMAN) ? pac_dir_reg : gdir_reg[gidx];
    assign nxt_x    = bus.map_wall ? cur_x_reg : cand_x_reg;
    assign nxt_y    = bus.map_wall ? cur_y_reg : cand_y_reg;

    // The stepper works on the read data while it is valid (LATCH), so the
    // candidate can be presented to the wall map as a registered address at
    // the start of QUERY.
    next_cell #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_cell (
        .x      (bus.reg_x_rd),
        .y      (bus.reg_y_rd),
        .dir    (step_dir),
        .cand_x (step_x),
        .cand_y (step_y)
    );

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            idx_reg       <= 3'd0;
            pac_dir_reg   <= DIR_UP;
            for (int i = 0; i < 4; i++) gdir_reg[i] <= DIR_UP;
            lfsr_reg      <= LFSR_SEED;
            cur_x_reg     <= 5'd0;
            cur_y_reg     <= 5'd0;
            cand_x_reg    <= 5'd0;
            cand_y_reg    <= 5'd0;
            pac_x_reg     <= 5'd0;
            pac_y_reg     <= 5'd0;
            coll_acc_reg  <= 1'b0;
            collision_reg <= 1'b0;
            reg_type_reg  <= 3'd0;
            reg_en_reg    <= 1'b0;
            reg_rw_reg    <= 1'b0;
            reg_x_wr_reg  <= 5'd0;
            reg_y_wr_reg  <= 5'd0;
            map_x_reg     <= 5'd0;
            map_y_reg     <= 5'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // Outputs are registered and decoded for the state being entered;
            // everything returns to zero unless that state asserts it.
            reg_type_reg <= 3'd0;
            reg_en_reg   <= 1'b0;
            reg_rw_reg   <= 1'b0;
            reg_x_wr_reg <= 5'd0;
            reg_y_wr_reg <= 5'd0;
            map_x_reg    <= 5'd0;
            map_y_reg    <= 5'd0;
            done_reg     <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        idx_reg <= TYPE_PACMAN;
                        if (pac_dir_valid) pac_dir_reg <= pac_dir;
                        state_reg    <= RD;
                        reg_en_reg   <= 1'b1;
                        reg_rw_reg   <= 1'b1;
                        reg_type_reg <= TYPE_PACMAN;
                        busy_reg     <= 1'b1;
                    end
                end
                RD: state_reg <= LATCH;
                LATCH: begin
                    cur_x_reg  <= bus.reg_x_rd;
                    cur_y_reg  <= bus.reg_y_rd;
                    cand_x_reg <= step_x;
                    cand_y_reg <= step_y;
                    map_x_reg  <= step_x;
                    map_y_reg  <= step_y;
                    state_reg  <= QUERY;
                end
                QUERY: state_reg <= DECIDE;
                DECIDE: begin
                    reg_en_reg   <= 1'b1;
                    reg_type_reg <= idx_reg;
                    reg_x_wr_reg <= nxt_x;
                    reg_y_wr_reg <= nxt_y;
                    if (idx_reg == TYPE_PACMAN) begin
                        pac_x_reg <= nxt_x;
                        pac_y_reg <= nxt_y;
                    end else begin
                        if (nxt_x == pac_x_reg && nxt_y == pac_y_reg) coll_acc_reg <= 1'b1;
                        // A blocked ghost picks a pseudo-random new heading.
                        if (bus.map_wall) begin
                            gdir_reg[gidx] <= lfsr_reg[1:0];
                            lfsr_reg       <= lfsr_step(lfsr_reg);
                        end
                    end
                    state_reg <= WR;
                end
                WR: begin
                    if (idx_reg == TYPE_GHOST4) begin
                        state_reg     <= FIN;
                        done_reg      <= 1'b1;
                        collision_reg <= coll_acc_reg;
                        coll_acc_reg  <= 1'b0;
                    end else begin
                        idx_reg      <= idx_reg + 3'd1;
                        state_reg    <= RD;
                        reg_en_reg   <= 1'b1;
                        reg_rw_reg   <= 1'b1;
                        reg_type_reg <= idx_reg + 3'd1;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_type      = reg_type_reg;
    assign bus.reg_en        = reg_en_reg;
    assign bus.reg_readwrite = reg_rw_reg;
    assign bus.reg_x_wr      = reg_x_wr_reg;
    assign bus.reg_y_wr      = reg_y_wr_reg;
    assign bus.map_x         = map_x_reg;
    assign bus.map_y         = map_y_reg;
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign collision         = collision_reg;
endmodule

// File: tb/tb_character_mover.sv
// Bench for character_mover: behavioural character register and wall map,
// expected writes and collision results queued by the stimulus and popped
// by independent monitors on every write strobe and done pulse.
module tb_character_mover;
    logic       clock_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] pac_dir = 2'b00;
    logic       pac_dir_valid = 1'b0;
    logic       busy, done, collision;

    character_mover_if bus ();

    character_mover #(
        .GRID_W    (20),
        .GRID_H    (15),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clock_50      (clock_50),
        .reset_n       (reset_n),
        .tick          (tick),
        .pac_dir       (pac_dir),
        .pac_dir_valid (pac_dir_valid),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .collision     (collision)
    );

    always #10 clock_50 = ~clock_50;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] t;
        logic [4:0] x;
        logic [4:0] y;
    } wr_t;

    wr_t wq[$];
    bit  cq[$];

    // Character register and wall map models.
    logic [4:0] rx [0:4];
    logic [4:0] ry [0:4];
    bit         wall [0:31][0:31];
    logic       ld_req = 1'b0;
    logic [2:0] ld_t = 3'd0;
    logic [4:0] ld_x = 5'd0, ld_y = 5'd0;

    initial begin
        bus.reg_x_rd = 5'd0;
        bus.reg_y_rd = 5'd0;
        bus.map_wall = 1'b0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) wall[i][j] = 1'b0;
    end

    always @(posedge clock_50) begin
        if (ld_req) begin
            rx[ld_t] <= ld_x;
            ry[ld_t] <= ld_y;
        end else if (bus.reg_en && !bus.reg_readwrite && bus.reg_type < 3'd5) begin
            rx[bus.reg_type] <= bus.reg_x_wr;
            ry[bus.reg_type] <= bus.reg_y_wr;
        end
        if (bus.reg_en && bus.reg_readwrite && bus.reg_type < 3'd5) begin
            bus.reg_x_rd <= rx[bus.reg_type];
            bus.reg_y_rd <= ry[bus.reg_type];
        end
        bus.map_wall <= wall[bus.map_x][bus.map_y];
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic set_char(input int t, input int x, input int y);
        @(negedge clock_50);
        ld_t = 3'(t); ld_x = 5'(x); ld_y = 5'(y); ld_req = 1'b1;
        @(negedge clock_50);
        ld_req = 1'b0;
    endtask

    task automatic exp_wr(input int t, input int x, input int y);
        wr_t e;
        e.t = 3'(t); e.x = 5'(x); e.y = 5'(y);
        wq.push_back(e);
    endtask

    // Write monitor.
    always @(negedge clock_50) begin
        if (bus.reg_en && !bus.reg_readwrite) begin
            wr_t e;
            checks++;
            $display("wr type=%0d x=%0d y=%0d", bus.reg_type, bus.reg_x_wr, bus.reg_y_wr);
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got type=%0d (%0d,%0d) want none",
                         bus.reg_type, bus.reg_x_wr, bus.reg_y_wr);
            end else begin
                e = wq.pop_front();
                if (bus.reg_type != e.t || bus.reg_x_wr != e.x || bus.reg_y_wr != e.y) begin
                    errors++;
                    $display("FAIL write got type=%0d (%0d,%0d) want type=%0d (%0d,%0d)",
                             bus.reg_type, bus.reg_x_wr, bus.reg_y_wr, e.t, e.x, e.y);
                end
            end
        end
    end

    // Pass-completion monitor.
    always @(negedge clock_50) begin
        if (done) begin
            checks++;
            $display("done collision=%0d", collision);
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got collision=%0d want no done", collision);
            end else begin
                bit c;
                c = cq.pop_front();
                if (collision != c) begin
                    errors++;
                    $display("FAIL collision got %0d want %0d", collision, c);
                end
            end
            chk("writes_before_done", wq.size(), 0);
        end
    end

    task automatic run_pass(input logic [1:0] pd, input logic pdv, input int abort_cyc,
                            input bit retrig, input bit chk_map, input int mx, input int my,
                            input int coll_start);
        int cyc;
        bit got;
        @(negedge clock_50);
        pac_dir = pd; pac_dir_valid = pdv; tick = 1'b1;
        @(negedge clock_50);
        tick = 1'b0; pac_dir_valid = 1'b0; pac_dir = ~pd;
        cyc = 1;
        got = 1'b0;
        chk("busy_rise", busy, 1);
        while (!got && cyc <= 40) begin
            tick = retrig && (cyc == 5 || cyc == 26);
            if (coll_start >= 0 && cyc == 1) chk("collision_held", collision, coll_start);
            if (chk_map && cyc == 3) begin
                chk("map_x", bus.map_x, mx);
                chk("map_y", bus.map_y, my);
            end
            if (abort_cyc == cyc) begin
                reset_n = 1'b0;
                @(negedge clock_50);
                reset_n = 1'b1;
                chk("abort_busy", busy, 0);
                chk("abort_reg_en", bus.reg_en, 0);
                return;
            end
            if (done) begin
                chk("done_cycle", cyc, 26);
                chk("busy_with_done", busy, 1);
                got = 1'b1;
            end else begin
                @(negedge clock_50);
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done want done by cycle 26");
        end
        @(negedge clock_50);
        tick = 1'b0;
        chk("busy_after_done", busy, 0);
        repeat (2) @(negedge clock_50);
        chk("still_idle", busy, 0);
    endtask

    initial begin
        // Reset and idle.
        repeat (3) @(negedge clock_50);
        chk("reset_outputs", {busy, done, collision, bus.reg_en, bus.reg_readwrite,
                              bus.reg_type, bus.reg_x_wr, bus.reg_y_wr, bus.map_x, bus.map_y}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_50);
            chk("idle_outputs", {busy, done, collision, bus.reg_en, bus.reg_readwrite,
                                 bus.reg_type, bus.reg_x_wr, bus.reg_y_wr, bus.map_x, bus.map_y}, 0);
        end

        // Pass 1: open map, Pacman right, ghosts up; retrigger ticks ignored.
        set_char(0, 2, 2); set_char(1, 5, 5); set_char(2, 10, 3);
        set_char(3, 7, 0); set_char(4, 1, 9);
        exp_wr(0, 3, 2); exp_wr(1, 5, 4); exp_wr(2, 10, 2); exp_wr(3, 7, 14); exp_wr(4, 1, 8);
        cq.push_back(1'b0);
        run_pass(2'b01, 1'b1, 0, 1'b1, 1'b0, 0, 0, 0);

        // Pass 2: walls block Pacman, ghost1 and ghost4.
        set_char(0, 2, 2);
        wall[3][2] = 1'b1; wall[5][3] = 1'b1; wall[1][7] = 1'b1;
        exp_wr(0, 2, 2); exp_wr(1, 5, 4); exp_wr(2, 10, 1); exp_wr(3, 7, 13); exp_wr(4, 1, 8);
        cq.push_back(1'b0);
        run_pass(2'b01, 1'b1, 0, 1'b0, 1'b0, 0, 0, 0);

        // Pass 3: new ghost headings (g1 right, g4 down), ghost3 meets Pacman.
        wall[3][2] = 1'b0; wall[5][3] = 1'b0; wall[1][7] = 1'b0;
        set_char(0, 2, 2); set_char(3, 3, 3); set_char(4, 4, 14);
        exp_wr(0, 3, 2); exp_wr(1, 6, 4); exp_wr(2, 10, 0); exp_wr(3, 3, 2); exp_wr(4, 4, 0);
        cq.push_back(1'b1);
        run_pass(2'b10, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);

        // Pass 4: Pacman tunnels left; collision held at pass start, then clears.
        set_char(0, 0, 5);
        exp_wr(0, 19, 5); exp_wr(1, 7, 4); exp_wr(2, 10, 14); exp_wr(3, 3, 1); exp_wr(4, 4, 1);
        cq.push_back(1'b0);
        run_pass(2'b11, 1'b1, 0, 1'b0, 1'b1, 19, 5, 1);

        // Pass 5: reset during ghost2 read aborts the pass.
        exp_wr(0, 18, 5); exp_wr(1, 8, 4);
        run_pass(2'b00, 1'b0, 11, 1'b0, 1'b0, 0, 0, -1);
        repeat (5) @(negedge clock_50);
        chk("abort_collision", collision, 0);
        chk("abort_busy_later", busy, 0);
        chk("pac_x_kept", rx[0], 18);
        chk("g1_x_kept", rx[1], 8);
        chk("g2_y_untouched", ry[2], 14);
        chk("g3_y_untouched", ry[3], 1);
        chk("g4_y_untouched", ry[4], 1);
        chk("write_queue_empty", wq.size(), 0);
        chk("done_queue_empty", cq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/character_mover.md
# character_mover

Per-frame movement sequencer for Pacman and the four ghosts. On each `tick` it walks all five characters in type order 0..4. For each one it reads the coordinates from the character register, forms a candidate next cell from that character's direction, and checks the candidate against the maze wall map. It then writes the result back and, after the last character, flags any Pacman/ghost collision. It sits directly upstream of the character register, drives that register's read/write port, and is the only writer of that register.

## Interface
Parameters:
- GRID_W, 20, maze width in cells; valid x range 0..GRID_W-1
- GRID_H, 15, maze height in cells; valid y range 0..GRID_H-1
- LFSR_SEED, 8'hA5, reset value of the ghost-direction LFSR; must be nonzero

Ports:
- clock_50  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  one-cycle pulse that starts one movement pass
- pac_dir  in  2  requested Pacman direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- pac_dir_valid  in  1  pac_dir is sampled when tick is accepted
- reg_type  out  3  character select to the register: 0 Pacman, 1..4 ghosts
- reg_en  out  1  register access strobe
- reg_readwrite  out  1  1 = read, 0 = write
- reg_x_wr, reg_y_wr  out  5 each  coordinates to write
- reg_x_rd, reg_y_rd  in  5 each  read data; valid on the cycle after the read strobe
- map_x, map_y  out  5 each  wall-map query address
- map_wall  in  1  wall flag; valid one cycle after the address is presented
- busy  out  1  high from accepted tick until done
- done  out  1  one-cycle pulse when a pass completes
- collision  out  1  registered result of the last pass; held until the next done

## Operation
- FSM states: IDLE, RD, LATCH, QUERY, DECIDE, WR, FIN.
- IDLE:
  - A tick loads idx=0.
  - If pac_dir_valid is high, pac_dir is copied into pac_dir_r.
  - Next state is RD.
- RD: reg_en=1, reg_readwrite=1, reg_type=idx.
- LATCH: captures reg_x_rd/reg_y_rd into cur_x/cur_y.
- QUERY:
  - Computes the candidate cell from cur_x/cur_y and the character's direction register.
  - Direction is pac_dir_r for idx 0 and gdir[idx] for ghosts.
  - Drives the candidate onto map_x/map_y.
- DECIDE, using map_wall:
  - No wall: nxt = candidate.
  - Wall: nxt = cur, position unchanged.
  - Wall on a ghost: gdir[idx] <= lfsr[1:0], and the LFSR advances one step.
  - Wall on Pacman: pac_dir_r is unchanged.
- WR:
  - reg_en=1, reg_readwrite=0, reg_type=idx, reg_x_wr/reg_y_wr=nxt.
  - idx 0: nxt is saved as pac_x/pac_y.
  - idx 1..4: nxt is compared with pac_x/pac_y; a match sets the coll_acc accumulator.
  - idx<4 goes to RD with idx+1; idx=4 goes to FIN.
- FIN: collision <= coll_acc, done=1, coll_acc cleared, next state IDLE.
- Wrap-around (tunnel), applied to the candidate before the wall query:
  - x=0 moving left becomes GRID_W-1; x=GRID_W-1 moving right becomes 0.
  - Same rule for y with GRID_H.
- Arithmetic: 5-bit unsigned. The compare to the boundary is made before any increment or decrement, so the result never exceeds the grid.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances only on a ghost wall hit.
- Outputs are idle-low: reg_en, done and busy are 0 outside their states; address buses hold 0 in IDLE.

## Timing
- Per character: 5 cycles (RD, LATCH, QUERY, DECIDE, WR).
- A full pass is 26 cycles from the accepted tick to the done pulse, including FIN.
- busy rises on the cycle after the accepted tick and falls with done.
- A tick while busy=1 is ignored and not queued.
- A tick on the same cycle as done is also ignored; a tick is accepted only in IDLE.
- Reset (reset_n=0 at posedge) values:
  - FSM=IDLE, idx=0, all outputs 0, collision=0.
  - pac_dir_r=00, all gdir=00, lfsr=LFSR_SEED.
- Reset mid-pass aborts immediately with no further register access. Characters already written keep their new values.

## Structure
- Shared package `pacman_pkg`:
  - Direction encoding constants DIR_UP/RIGHT/DOWN/LEFT.
  - Character type constants TYPE_PACMAN, TYPE_GHOST1..4.
  - FSM state encoding.
- One sub-module, `next_cell`: combinational wrap-around stepper; inputs x, y, dir; outputs candidate x, y; parameterised by GRID_W and GRID_H.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, busy=0, no reg_en pulses.
- Pacman at (2,2), pac_dir=01 valid, map all open, tick -> write of type 0 with (3,2); done at cycle 26; each ghost written one cell up from its read value.
- Pacman at (0,5) moving left, open map -> map query (19,5), write (19,5). Ghost at (4,14) moving down -> write (4,0).
- Wall at (3,2), Pacman (2,2) right -> write (2,2). Ghost1 hits a wall -> gdir1 = LFSR_SEED[1:0]; following pass uses that direction.
- Ghost3 lands on Pacman's new cell -> collision=1 after done, held through the next pass start; a later clean pass -> collision=0.
- Tick pulsed again at cycles 5 and 26 of a pass -> ignored, single done. reset_n=0 during ghost2 RD -> no write for types 2..4, FSM in IDLE next cycle.
